// File: rtl/z3_slave_seq_pkg.sv
// Shared definitions for the Zorro III slave-cycle sequencer: state encoding and field widths.
package z3_slave_seq_pkg;

    localparam int REGION_IDX_W = 4;
    localparam int TMO_CNT_W    = 8;

    typedef enum logic [2:0] {
        Z3_IDLE  = 3'd0,
        Z3_START = 3'd1,
        Z3_DATA  = 3'd2,
        Z3_END   = 3'd3,
        Z3_ERR   = 3'd4
    } z3_state_e;

endpackage

// File: rtl/z3_sync.sv
// Single-bit multi-flop synchroniser with asynchronous clear, used for the raw DS_n/DOE bus strobes.
module z3_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sh;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) sh <= '0;
        else          sh <= {sh[STAGES-2:0], d};
    end

    assign q = sh[STAGES-1];

endmodule

// File: rtl/z3_slave_seq.sv
// Zorro III slave-cycle sequencer serving NUM_REGIONS decoded targets through a req/ack handshake.
// Optional data-phase timeout with BERR is enabled by defining Z3_SLAVE_TIMEOUT_EN.
module z3_slave_seq
    import z3_slave_seq_pkg::*;
#(
    parameter int NUM_REGIONS    = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RESET_n,
    input  logic                    bfcs,
    input  logic                    match,
    input  logic                    validspace,
    input  logic                    ds_active,
    input  logic                    doe,
    input  logic [NUM_REGIONS-1:0]  region_sel,
    input  logic [NUM_REGIONS-1:0]  region_ack,
    output logic [NUM_REGIONS-1:0]  region_req,
    output logic [3:0]              cur_region,
    output logic                    dtack,
    output logic                    slave,
    output logic                    berr
);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_err
        $error("z3_slave_seq: parameter out of range");
    end

    function automatic logic [REGION_IDX_W-1:0] lowest_idx(input logic [NUM_REGIONS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (v[i]) lowest_idx = REGION_IDX_W'(i);
    endfunction

    z3_state_e                state, state_n;
    logic [NUM_REGIONS-1:0]   sel_oh, oh_n;
    logic [REGION_IDX_W-1:0]  idx_n;
    logic [1:0]               raw, syn;
    logic                     ds_sync, doe_sync;
    logic                     start_cond, ack_hit;

    assign raw = {doe, ds_active};

    for (genvar i = 0; i < 2; i++) begin : g_sync
        z3_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .CLK     (CLK),
            .RESET_n (RESET_n),
            .d       (raw[i]),
            .q       (syn[i])
        );
    end

    assign ds_sync  = syn[0];
    assign doe_sync = syn[1];

    assign start_cond = !bfcs && match && validspace && (|region_sel);
    assign idx_n      = lowest_idx(region_sel);

    always_comb begin
        oh_n = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            oh_n[i] = (REGION_IDX_W'(i) == idx_n);
    end

    // Only the latched region's ack can complete the cycle.
    assign ack_hit = |(region_ack & sel_oh);

`ifdef Z3_SLAVE_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_CNT_W-1:0] cnt;

    // Counts completed DATA cycles; zero on every DATA entry, saturating.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)                cnt <= '0;
        else if (state != Z3_DATA)   cnt <= '0;
        else if (cnt != '1)          cnt <= cnt + TMO_CNT_W'(1);
    end
`endif

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= Z3_IDLE;
            cur_region <= '0;
            sel_oh     <= '0;
        end else begin
            state <= state_n;
            if (state == Z3_IDLE && start_cond) begin
                cur_region <= idx_n;
                sel_oh     <= oh_n;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            Z3_IDLE:  if (start_cond)                state_n = Z3_START;
            Z3_START: if (bfcs)                      state_n = Z3_IDLE;
                      else if (ds_sync && doe_sync)  state_n = Z3_DATA;
            Z3_DATA:  if (bfcs)                      state_n = Z3_IDLE;
                      else if (ack_hit)              state_n = Z3_END;
`ifdef Z3_SLAVE_TIMEOUT_EN
                      else if (cnt >= TMO_LAST)      state_n = Z3_ERR;
`endif
            Z3_END:   if (bfcs)                      state_n = Z3_IDLE;
`ifdef Z3_SLAVE_TIMEOUT_EN
            Z3_ERR:   if (bfcs)                      state_n = Z3_IDLE;
`endif
            default:                                 state_n = Z3_IDLE;
        endcase
    end

    always_comb begin
        region_req = '0;
        if (state == Z3_START || state == Z3_DATA || state == Z3_END)
            region_req = sel_oh;
    end

    assign dtack = (state == Z3_END);

`ifdef Z3_SLAVE_TIMEOUT_EN
    assign berr = (state == Z3_ERR);
`else
    assign berr = 1'b0;
`endif

    // Reset gating keeps SLAVE_n released while IORST_n is asserted.
    assign slave = RESET_n && (start_cond || (state != Z3_IDLE && !bfcs));

endmodule

// File: tb/tb_z3_slave_seq.sv
// Randomised self-checking bench for z3_slave_seq against a cycle-arithmetic transaction model.
module tb_z3_slave_seq;

    localparam int NR = 8;
    localparam int SS = 2;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RESET_n;
    logic          bfcs, match, validspace, ds_active, doe;
    logic [NR-1:0] region_sel, region_ack, region_req;
    logic [3:0]    cur_region;
    logic          dtack, slave, berr;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 CLK = ~CLK;

    z3_slave_seq #(.NUM_REGIONS(NR), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .bfcs       (bfcs),
        .match      (match),
        .validspace (validspace),
        .ds_active  (ds_active),
        .doe        (doe),
        .region_sel (region_sel),
        .region_ack (region_ack),
        .region_req (region_req),
        .cur_region (cur_region),
        .dtack      (dtack),
        .slave      (slave),
        .berr       (berr)
    );

    task automatic drive_idle();
        bfcs = 1'b1; match = 1'b0; validspace = 1'b0;
        ds_active = 1'b0; doe = 1'b0;
        region_sel = '0; region_ack = '0;
    endtask

    // Edge k is the k-th rising edge after the one that first sees FCS low (k=0).
    // DS/DOE first seen at edge d, selected ack first seen at edge a, bfcs high seen at edge b.
    task automatic run_txn(input logic [NR-1:0] sel, input logic [NR-1:0] later,
                           input int d, input int a, input int b,
                           input logic [NR-1:0] noise_mask, input int gap, input string tag);
        int idx, data_e, e2, to_e, p;
        bit tmo;
        logic [NR-1:0] oh, exp_req;
        logic exp_dt, exp_be;
        idx = 0;
        for (int i = NR - 1; i >= 0; i--) if (sel[i]) idx = i;
        oh = '0;
        oh[idx] = 1'b1;
        data_e = (d + SS > 1) ? d + SS : 1;
        e2 = (a > data_e + 1) ? a : data_e + 1;
`ifdef Z3_SLAVE_TIMEOUT_EN
        to_e = data_e + TO;
        tmo  = (e2 > to_e);
`else
        to_e = 0;
        tmo  = 1'b0;
`endif
        for (int k = 0; k <= b + gap; k++) begin
            if (k >= 1) begin
                p = k - 1;
                exp_dt  = !tmo && p >= e2 && p < b;
                exp_be  = tmo && p >= to_e && p < b;
                exp_req = (p < b && !(tmo && p >= to_e)) ? oh : '0;
                n_checks++;
                if (dtack !== exp_dt) begin
                    n_fail++;
                    $display("FAIL %s dtack cyc%0d: got %b want %b", tag, p, dtack, exp_dt);
                end
                n_checks++;
                if (berr !== exp_be) begin
                    n_fail++;
                    $display("FAIL %s berr cyc%0d: got %b want %b", tag, p, berr, exp_be);
                end
                n_checks++;
                if (region_req !== exp_req) begin
                    n_fail++;
                    $display("FAIL %s region_req cyc%0d: got %h want %h", tag, p, region_req, exp_req);
                end
                n_checks++;
                if (cur_region !== 4'(idx)) begin
                    n_fail++;
                    $display("FAIL %s cur_region cyc%0d: got %0d want %0d", tag, p, cur_region, idx);
                end
            end
            bfcs       = (k >= b);
            match      = (k < b);
            validspace = (k < b);
            region_sel = (k == 0) ? sel : ((k < b) ? later : '0);
            ds_active  = (k >= d && k < b);
            doe        = (k >= d && k < b);
            region_ack = (k < b) ? (((k >= a) ? oh : '0) | (NR'($urandom) & noise_mask & ~oh)) : '0;
            #1;
            n_checks++;
            if (slave !== (k < b)) begin
                n_fail++;
                $display("FAIL %s slave cyc%0d: got %b want %b", tag, k, slave, (k < b));
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        bfcs = 1'b0; match = 1'b1; validspace = 1'b1;
        ds_active = 1'b1; doe = 1'b1;
        region_sel = 8'h01; region_ack = 8'hFF;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({dtack, slave, berr} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset dtack/slave/berr: got %b want 000", {dtack, slave, berr});
        end
        n_checks++;
        if (region_req !== '0 || cur_region !== 4'd0) begin
            n_fail++;
            $display("FAIL reset req/cur: got %h/%0d want 00/0", region_req, cur_region);
        end
        drive_idle();
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (4) @(negedge CLK);
        n_checks++;
        if ({dtack, slave, berr} !== 3'b000 || region_req !== '0) begin
            n_fail++;
            $display("FAIL post_reset idle: got %b/%h want 000/00", {dtack, slave, berr}, region_req);
        end
    endtask

    task automatic test_read_region3();
        run_txn(8'h08, 8'h08, 0, 6, 10, '0, 3, "read_r3");
    endtask

    task automatic test_abort();
        run_txn(8'h24, 8'h24, 1, 100, 4, '0, 3, "abort");
    endtask

    task automatic test_priority();
        run_txn(8'h0A, 8'h80, 0, 8, 12, 8'h80, 3, "priority");
    endtask

    task automatic test_bfcs_wins();
        run_txn(8'h10, 8'h10, 0, 5, 5, '0, 3, "bfcs_wins");
    endtask

    task automatic test_no_select();
        bfcs = 1'b0; match = 1'b1; validspace = 1'b1;
        ds_active = 1'b1; doe = 1'b1; region_sel = '0; region_ack = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (slave !== 1'b0) begin
                n_fail++;
                $display("FAIL no_select slave cyc%0d: got %b want 0", k, slave);
            end
            @(negedge CLK);
            n_checks++;
            if (region_req !== '0 || dtack !== 1'b0) begin
                n_fail++;
                $display("FAIL no_select req/dtack cyc%0d: got %h/%b want 00/0", k, region_req, dtack);
            end
        end
        validspace = 1'b0; region_sel = 8'h20;
        #1;
        n_checks++;
        if (slave !== 1'b0) begin
            n_fail++;
            $display("FAIL no_validspace slave: got %b want 0", slave);
        end
        @(negedge CLK);
        n_checks++;
        if (region_req !== '0) begin
            n_fail++;
            $display("FAIL no_validspace req: got %h want 00", region_req);
        end
        drive_idle();
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        run_txn(8'h02, 8'h00, 0, 3, 6, 8'hFF, 0, "b2b_0");
        run_txn(8'h40, 8'hFF, 0, 0, 5, 8'hFF, 0, "b2b_1");
        run_txn(8'h81, 8'h01, 0, 4, 7, 8'hFF, 3, "b2b_2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++)
            run_txn(NR'($urandom_range(1, 255)), NR'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 12), $urandom_range(1, 18), 8'hFF,
                    $urandom_range(0, 3), "random");
    endtask

    task automatic test_timeout();
`ifdef Z3_SLAVE_TIMEOUT_EN
        run_txn(8'h01, 8'h01, 0, 5000, 40, '0, 4, "timeout");
`else
        run_txn(8'h01, 8'h01, 0, 5000, 1000, '0, 4, "no_timeout");
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        bfcs = 1'b0; match = 1'b1; validspace = 1'b1;
        ds_active = 1'b1; doe = 1'b1; region_sel = 8'h40; region_ack = 8'h40;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLK);
            if (dtack === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid dtack_seen: got 0 want 1 within 20 clks");
        end
        #5 RESET_n = 1'b0;
        #1;
        n_checks++;
        if ({dtack, slave, berr} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid dtack/slave/berr: got %b want 000", {dtack, slave, berr});
        end
        n_checks++;
        if (region_req !== '0 || cur_region !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid req/cur: got %h/%0d want 00/0", region_req, cur_region);
        end
        drive_idle();
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (dtack !== 1'b0 || region_req !== '0) begin
            n_fail++;
            $display("FAIL reset_mid release: got %b/%h want 0/00", dtack, region_req);
        end
    endtask

    initial begin
        drive_idle();
        RESET_n = 1'b0;
        test_reset();
        test_read_region3();
        test_abort();
        test_priority();
        test_bfcs_wins();
        test_no_select();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
